// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg -- shared definitions for the ctrl_seq instruction sequencer.
//   opcode_e   : 3-bit opcode encoding of the 8-bit instruction word
//   state_e    : sequencer FSM states
//   *_LSB/*_W  : instruction field positions and widths
//   writes_reg : opcodes that commit a result to the register file
package ctrl_seq_pkg;

   localparam int INSTR_W = 8;   // minimum width holding opcode/dest/imm fields
   localparam int OP_LSB  = 5;
   localparam int OP_W    = 3;
   localparam int RD_LSB  = 3;
   localparam int RD_W    = 2;
   localparam int IMM_LSB = 0;
   localparam int IMM_W   = 3;

   typedef enum logic [OP_W-1:0] {
      OP_NOP = 3'b000,
      OP_LDI = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b011,
      OP_AND = 3'b100,
      OP_OR  = 3'b101,
      OP_JMP = 3'b110,
      OP_HLT = 3'b111
   } opcode_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } state_e;

   // NOP, JMP and HLT leave the register file untouched.
   function automatic logic writes_reg(input opcode_e op);
      return (op != OP_NOP) && (op != OP_JMP) && (op != OP_HLT);
   endfunction

endpackage

// File: rtl/ctrl_seq_imm_ext.sv
// imm_ext -- zero-extends the 3-bit immediate field to the datapath width.
//   field_i : instruction immediate field
//   imm_o   : field_i zero-extended to N bits
module imm_ext
   import ctrl_seq_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [IMM_W-1:0] field_i,
   output logic [N-1:0]     imm_o
);

   assign imm_o = {{(N-IMM_W){1'b0}}, field_i};

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq -- multi-cycle instruction sequencer (IDLE/FETCH/DECODE/EXEC/HALT).
//   clk, rst_n       : clock, synchronous active-low reset
//   start            : leaves IDLE
//   instr/instr_valid: program-memory response, accepted only in FETCH
//   fetch_req, pc    : fetch request and address
//   alu_op/imm/reg_sel/reg_we : decoded controls to ALU and register file
//   busy, halted, err: status
// Optional build macro CTRL_SEQ_WDT_EN adds a fetch watchdog: after
// FETCH_TIMEOUT idle FETCH cycles the sequencer halts with a sticky err.
module ctrl_seq
   import ctrl_seq_pkg::*;
#(
   parameter int N             = 8,
   parameter int FETCH_TIMEOUT = 15
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] instr,
   input  logic         instr_valid,
   output logic         fetch_req,
   output logic [N-1:0] pc,
   output logic [2:0]   alu_op,
   output logic [N-1:0] imm,
   output logic [1:0]   reg_sel,
   output logic         reg_we,
   output logic         busy,
   output logic         halted,
   output logic         err
);

   if ((N < INSTR_W) || (FETCH_TIMEOUT < 1)) begin : g_bad_cfg
      $error("ctrl_seq: N must be >= 8 and FETCH_TIMEOUT >= 1");
   end

   state_e       state_q, state_d;
   logic [N-1:0] pc_q, pc_d;
   logic [N-1:0] ir_q, ir_d;
   opcode_e      op_w;
   logic [N-1:0] imm_w;
   logic         wdt_fire;

   // Decoded fields come straight from the latched instruction, so they are
   // stable from DECODE through EXEC and read 0 after reset.
   assign op_w    = opcode_e'(ir_q[OP_LSB +: OP_W]);
   assign alu_op  = ir_q[OP_LSB +: OP_W];
   assign reg_sel = ir_q[RD_LSB +: RD_W];
   assign imm     = imm_w;
   assign pc      = pc_q;

   imm_ext #(.N(N)) u_imm_ext (
      .field_i (ir_q[IMM_LSB +: IMM_W]),
      .imm_o   (imm_w)
   );

`ifdef CTRL_SEQ_WDT_EN
   localparam int WDT_W = $clog2(FETCH_TIMEOUT + 1);

   logic [WDT_W-1:0] wdt_q, wdt_d;
   logic             err_q, err_d;

   // Counts consecutive FETCH cycles without instr_valid; fires on the
   // FETCH_TIMEOUT-th such cycle.
   assign wdt_fire = (state_q == S_FETCH) && !instr_valid &&
                     (wdt_q == WDT_W'(FETCH_TIMEOUT - 1));

   always_comb begin
      wdt_d = '0;
      if ((state_q == S_FETCH) && !instr_valid)
         wdt_d = wdt_q + WDT_W'(1);
      err_d = err_q | wdt_fire;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wdt_q <= '0;
         err_q <= 1'b0;
      end else begin
         wdt_q <= wdt_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign wdt_fire = 1'b0;
   assign err      = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_FETCH;
         S_FETCH: begin
            if (instr_valid)   state_d = S_DECODE;
            else if (wdt_fire) state_d = S_HALT;
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC:   state_d = (op_w == OP_HLT) ? S_HALT : S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      fetch_req = 1'b0;
      reg_we    = 1'b0;
      busy      = 1'b0;
      halted    = 1'b0;
      case (state_q)
         S_FETCH: begin
            fetch_req = 1'b1;
            busy      = 1'b1;
         end
         S_DECODE: busy = 1'b1;
         S_EXEC: begin
            busy   = 1'b1;
            reg_we = writes_reg(op_w);
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

   // Datapath: instruction latch and program counter
   always_comb begin
      ir_d = ir_q;
      pc_d = pc_q;
      if ((state_q == S_FETCH) && instr_valid)
         ir_d = instr;
      if (state_q == S_EXEC) begin
         case (op_w)
            OP_JMP:  pc_d = pc_q + imm_w + N'(1);
            OP_HLT:  pc_d = pc_q;
            default: pc_d = pc_q + N'(1);
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q <= '0;
         ir_q <= '0;
      end else begin
         pc_q <= pc_d;
         ir_q <= ir_d;
      end
   end

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq -- scoreboard bench for ctrl_seq. Stimulus issues
// instructions and pushes the expected architectural effect of each one;
// a monitor pops on every accepted fetch and checks decode, execute and
// the resulting pc/status.
module tb_ctrl_seq;

   typedef struct {
      logic [7:0] pc;
      logic [7:0] npc;
      logic [2:0] op;
      logic [2:0] imm;
      logic [1:0] rd;
      logic       we;
      logic       hlt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] instr = 8'h00;
   logic       instr_valid = 1'b0;
   logic       fetch_req;
   logic [7:0] pc;
   logic [2:0] alu_op;
   logic [7:0] imm;
   logic [1:0] reg_sel;
   logic       reg_we;
   logic       busy;
   logic       halted;
   logic       err;

   int   n_chk = 0;
   int   n_err = 0;
   exp_t sb[$];
   exp_t me;
   bit   mon_en = 1'b1;
   bit   mon_busy = 1'b0;
   logic [7:0] m_pc = 8'h00;

   ctrl_seq #(.N(8), .FETCH_TIMEOUT(15)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .instr       (instr),
      .instr_valid (instr_valid),
      .fetch_req   (fetch_req),
      .pc          (pc),
      .alu_op      (alu_op),
      .imm         (imm),
      .reg_sel     (reg_sel),
      .reg_we      (reg_we),
      .busy        (busy),
      .halted      (halted),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Architectural effect of one instruction executed at address cur_pc.
   function automatic exp_t model(input logic [7:0] cur_pc, input logic [7:0] ins);
      exp_t e;
      e.pc  = cur_pc;
      e.op  = ins[7:5];
      e.rd  = ins[4:3];
      e.imm = ins[2:0];
      e.we  = (e.op >= 3'd1) && (e.op <= 3'd5);
      e.hlt = (e.op == 3'd7);
      if (e.hlt)             e.npc = cur_pc;
      else if (e.op == 3'd6) e.npc = cur_pc + {5'd0, e.imm} + 8'd1;
      else                   e.npc = cur_pc + 8'd1;
      return e;
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, "_pc"},        pc,        0);
      chk({tag, "_fetch_req"}, fetch_req, 0);
      chk({tag, "_reg_we"},    reg_we,    0);
      chk({tag, "_alu_op"},    alu_op,    0);
      chk({tag, "_imm"},       imm,       0);
      chk({tag, "_reg_sel"},   reg_sel,   0);
      chk({tag, "_busy"},      busy,      0);
      chk({tag, "_halted"},    halted,    0);
      chk({tag, "_err"},       err,       0);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_fetch_req", fetch_req, 1);
   endtask

   // Waits for FETCH, stalls dly cycles, presents ins; optionally raises a
   // spurious instr_valid during the following DECODE cycle.
   task automatic issue(input logic [7:0] ins, input int dly, input bit spur);
      int   w = 0;
      exp_t e;
      while (!fetch_req && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      if (!fetch_req) begin
         chk("fetch_req_timeout", fetch_req, 1);
         return;
      end
      repeat (dly) begin
         @(posedge clk); #1;
         chk("stall_fetch_req", fetch_req, 1);
         chk("stall_pc", pc, m_pc);
      end
      e = model(m_pc, ins);
      sb.push_back(e);
      m_pc = e.npc;
      instr = ins;
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      instr = 8'($urandom);
      if (spur) begin
         instr_valid = 1'b1;
         @(posedge clk); #1;
         instr_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int w = 0;
      while ((sb.size() != 0 || mon_busy) && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      chk("scoreboard_drained", (sb.size() == 0 && !mon_busy), 1);
   endtask

   // Monitor: one accepted fetch -> pop and follow it through DECODE, EXEC
   // and the cycle after. Re-tests the handshake on the last sampled edge
   // so a back-to-back fetch is not missed.
   initial begin
      forever begin
         @(negedge clk);
         while (mon_en && fetch_req && instr_valid) begin
            mon_busy = 1'b1;
            if (sb.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_fetch actual=pc %0h expected=no fetch", pc);
               @(negedge clk);
            end else begin
               me = sb.pop_front();
               chk("fetch_pc", pc, me.pc);
               @(negedge clk);
               chk("dec_alu_op",    alu_op,    me.op);
               chk("dec_imm",       imm,       me.imm);
               chk("dec_reg_sel",   reg_sel,   me.rd);
               chk("dec_reg_we",    reg_we,    0);
               chk("dec_busy",      busy,      1);
               chk("dec_fetch_req", fetch_req, 0);
               @(negedge clk);
               chk("exec_reg_we",  reg_we, me.we);
               chk("exec_alu_op",  alu_op, me.op);
               chk("exec_imm",     imm,    me.imm);
               @(negedge clk);
               chk("post_pc",        pc,        me.npc);
               chk("post_halted",    halted,    me.hlt);
               chk("post_busy",      busy,      !me.hlt);
               chk("post_fetch_req", fetch_req, !me.hlt);
               chk("post_reg_we",    reg_we,    0);
            end
            mon_busy = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] ins;
      int         n;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset("rst");
      rst_n = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b1;   // ignored in IDLE
      @(posedge clk); #1;
      instr_valid = 1'b0;
      chk("idle_busy", busy, 0);
      chk("idle_fetch_req", fetch_req, 0);
      chk("idle_pc", pc, 0);

      do_start();
      issue(8'h2D, 0, 1'b0);          // LDI r1,5 at pc 0
      issue(8'h00, 1, 1'b0);
      issue(8'h00, 0, 1'b1);
      issue(8'h00, 0, 1'b0);          // pc now 4
      issue(8'hC3, 0, 1'b0);          // JMP +3 -> pc 8
      issue(8'h10, 10, 1'b0);         // long fetch stall

      for (int i = 0; i < 250; i++) begin
         ins = {3'($urandom_range(0, 6)), 5'($urandom)};
         issue(ins, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
      end

      // Steer pc to 0xFF, then a NOP must wrap it to 0x00.
      n = 0;
      while (m_pc != 8'hFF && n < 64) begin
         issue((m_pc <= 8'hF7) ? 8'hC7 : 8'h00, 0, 1'b0);
         n++;
      end
      issue(8'h00, 0, 1'b0);
      issue(8'h00, 0, 1'b0);
      issue(8'hE0, 0, 1'b0);          // HLT
      wait_drain();

      chk("halt_halted", halted, 1);
      chk("halt_busy", busy, 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("halt_start_halted", halted, 1);
      chk("halt_start_pc", pc, m_pc);
      chk("halt_start_fetch_req", fetch_req, 0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_reset("halt_rst");
      rst_n = 1'b1;
      m_pc = 8'h00;

      // Reset while in DECODE.
      mon_en = 1'b0;
      @(posedge clk); #1;
      do_start();
      instr = 8'h2D;
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      chk("abort_dec_busy", busy, 1);
      chk("abort_dec_fetch_req", fetch_req, 0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_reset("abort");
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("abort_no_reg_we", reg_we, 0);
         chk("abort_idle_busy", busy, 0);
      end
      mon_en = 1'b1;

`ifdef CTRL_SEQ_WDT_EN
      do_start();
      repeat (16) @(posedge clk);
      #1;
      chk("wdt_halted", halted, 1);
      chk("wdt_err", err, 1);
      chk("wdt_busy", busy, 0);
      chk("wdt_fetch_req", fetch_req, 0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_reset("wdt_rst");
      rst_n = 1'b1;
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the datapath, instruction and PC width.
REQ-002 The block SHALL have parameter FETCH_TIMEOUT, default 15, meaning the maximum number of wait cycles per fetch (used only when CTRL_SEQ_WDT_EN is defined).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: begins execution from IDLE.
REQ-006 The block SHALL have port instr, input, N bits: instruction word from program memory.
REQ-007 The block SHALL have port instr_valid, input, 1 bit: instr is valid this cycle.
REQ-008 The block SHALL have port fetch_req, output, 1 bit: instruction fetch request.
REQ-009 The block SHALL have port pc, output, N bits: program counter and fetch address.
REQ-010 The block SHALL have port alu_op, output, 3 bits: operation select to the ALU.
REQ-011 The block SHALL have port imm, output, N bits: instr[2:0] zero-extended to N bits.
REQ-012 The block SHALL have port reg_sel, output, 2 bits: destination register, taken from instr[4:3].
REQ-013 The block SHALL have port reg_we, output, 1 bit: register-file write strobe.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state except IDLE and HALT.
REQ-015 The block SHALL have port halted, output, 1 bit: high in HALT.
REQ-016 The block SHALL have port err, output, 1 bit: fetch timeout flag (tied to 0 when CTRL_SEQ_WDT_EN is not defined).

Function
REQ-017 The instruction format SHALL be [7:5] opcode, [4:3] destination, [2:0] immediate, with opcodes 000 NOP, 001 LDI, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 JMP, 111 HLT.
REQ-018 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC and HALT.
REQ-019 IDLE SHALL go to FETCH on start=1; start SHALL be ignored in every other state.
REQ-020 In FETCH, fetch_req SHALL be held at 1 with pc stable until instr_valid=1; on that edge instr SHALL be latched and the FSM SHALL go to DECODE.
REQ-021 DECODE SHALL last one cycle and drive alu_op=opcode, imm and reg_sel from the latched instruction, holding them through EXEC.
REQ-022 EXEC SHALL last one cycle; reg_we SHALL pulse for exactly one cycle in EXEC for opcodes 001-101 only.
REQ-023 In EXEC, pc SHALL become pc+1 for all opcodes except JMP, where it SHALL become pc+imm+1, both modulo 2^N (255 wraps to 0), and the FSM SHALL then go to FETCH.
REQ-024 HLT SHALL move EXEC to HALT without changing pc; HALT SHALL be exited only by reset.
REQ-025 Fetch-to-fetch latency SHALL be 3 cycles when instr_valid is already high in FETCH.
REQ-026 An instr_valid pulse outside FETCH SHALL be ignored.

Reset
REQ-027 With rst_n=0 at a clock edge, the FSM SHALL enter IDLE and drive pc=0, fetch_req=0, reg_we=0, alu_op=0, imm=0, reg_sel=0, busy=0, halted=0 and err=0, from any state, including mid-fetch.

Configuration
REQ-028 When CTRL_SEQ_WDT_EN is defined, a counter SHALL run in FETCH; after FETCH_TIMEOUT cycles without instr_valid, the FSM SHALL enter HALT with err=1, which stays set until reset.
REQ-029 When CTRL_SEQ_WDT_EN is not defined, FETCH SHALL wait indefinitely, no counter SHALL be synthesized, and err SHALL be tied to 0.

Structure
REQ-030 The shared package ctrl_seq_pkg SHALL hold the opcode enum, the state enum and the field positions and widths.
REQ-031 Immediate extraction SHALL be the sub-module imm_ext: zero-extend the low 3 bits to N bits, upper bits 0.

Verification
REQ-032 Reset, then start=1, then instr=0x2D (LDI, r1, 5) with instr_valid=1 -> fetch_req=1 at pc=0, then imm=0x05, reg_sel=1, alu_op=001, a single reg_we pulse, and pc=1.
REQ-033 instr=0xC3 (JMP +3) at pc=4 -> pc=8 after EXEC and no reg_we pulse.
REQ-034 pc=0xFF with a NOP -> pc wraps to 0x00.
REQ-035 Hold instr_valid=0 for 10 cycles in FETCH -> fetch_req and pc stable, then normal completion; with CTRL_SEQ_WDT_EN defined and 16 idle cycles -> HALT with err=1.
REQ-036 instr=0xE0 (HLT) -> halted=1 and busy=0; a later start=1 -> no change; rst_n=0 -> IDLE with pc=0.
REQ-037 rst_n=0 during DECODE -> all outputs at their reset values on the next edge, and no reg_we pulse.
